// File: rtl/ldpc_pkg.sv
// Shared types and code points for the LDPC frame controller and its helpers.
package ldpc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // core_status encodings; 3 is reserved and behaves like BUSY
  localparam logic [1:0] STAT_BUSY = 2'd0;
  localparam logic [1:0] STAT_CONV = 2'd1;
  localparam logic [1:0] STAT_FAIL = 2'd2;

  // out_code encodings
  localparam logic [1:0] CODE_OK   = 2'd0;
  localparam logic [1:0] CODE_FAIL = 2'd1;
  localparam logic [1:0] CODE_TMO  = 2'd2;
  localparam logic [1:0] CODE_ABRT = 2'd3;

endpackage

// File: rtl/ldpc_sat_cnt.sv
// Saturating up-counter used for the frame statistics registers.
module ldpc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ldpc_dec_ctrl.sv
// Frame sequencer for ldpc_core: accepts a frame, clears and runs the core with a
// timeout, then presents the hard decisions and a completion code to the consumer.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid is
// held with its payload stable until that edge, ready may change freely.
module ldpc_dec_ctrl
  import ldpc_pkg::*;
#(
  parameter int data_w  = 5,
  parameter int R       = 24,
  parameter int D       = 96,
  parameter int TIMEOUT = 2048,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [R*D*data_w-1:0] in_sig,
  input  logic                  abort,
  output logic                  core_rst,
  output logic                  core_en,
  output logic [R*D*data_w-1:0] core_sig,
  input  logic [R*D-1:0]        core_res,
  input  logic [1:0]            core_status,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [R*D-1:0]        out_res,
  output logic [1:0]            out_code,
  output logic                  busy,
  output logic [CNT_W-1:0]      cnt_ok,
  output logic [CNT_W-1:0]      cnt_fail
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT - 1);

  state_t          state;
  logic   [CW-1:0] run_cnt;
  logic            clr_q;

  logic            finish;
  logic [1:0]      fin_code;
  logic [R*D-1:0]  fin_res;
  logic            ok_inc;
  logic            fail_inc;

  // The core clear follows the reset pin asynchronously so a mid-frame reset
  // stops the core immediately, not on the next clock.
  assign core_rst = clr_q | ~rst_n;

  // Completion decision for the current cycle; first match wins.
  always_comb begin
    finish   = 1'b0;
    fin_code = CODE_OK;
    fin_res  = '0;
    case (state)
      ST_CLEAR: begin
        if (abort) begin
          finish   = 1'b1;
          fin_code = CODE_ABRT;
        end
      end
      ST_RUN: begin
        if (abort) begin
          finish   = 1'b1;
          fin_code = CODE_ABRT;
        end else if (core_status == STAT_CONV) begin
          finish   = 1'b1;
          fin_code = CODE_OK;
          fin_res  = core_res;
        end else if (core_status == STAT_FAIL) begin
          finish   = 1'b1;
          fin_code = CODE_FAIL;
          fin_res  = core_res;
        end else if (run_cnt == RUN_LAST) begin
          finish   = 1'b1;
          fin_code = CODE_TMO;
        end
      end
      default: ;
    endcase
  end

  assign ok_inc   = finish && (fin_code == CODE_OK);
  assign fail_inc = finish && (fin_code != CODE_OK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      run_cnt   <= '0;
      clr_q     <= 1'b0;
      in_ready  <= 1'b1;
      core_en   <= 1'b0;
      core_sig  <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_code  <= CODE_OK;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            core_sig <= in_sig;
            state    <= ST_CLEAR;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            clr_q    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_q   <= 1'b0;
          run_cnt <= '0;
          if (finish) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_code  <= fin_code;
            out_res   <= fin_res;
          end else begin
            state   <= ST_RUN;
            core_en <= 1'b1;
          end
        end
        ST_RUN: begin
          if (finish) begin
            state     <= ST_DONE;
            core_en   <= 1'b0;
            out_valid <= 1'b1;
            out_code  <= fin_code;
            out_res   <= fin_res;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ldpc_sat_cnt #(.W(CNT_W)) u_cnt_ok (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ok_inc),
    .cnt   (cnt_ok)
  );

  ldpc_sat_cnt #(.W(CNT_W)) u_cnt_fail (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fail_inc),
    .cnt   (cnt_fail)
  );

endmodule
